collision_detector: RTL
=======================

// Module: collision_detector
// PURPOSE
//   Upstream stage of the game-state controller: produces its one-cycle `collision` input.
//   Observes the per-pixel sprite-membership flags emitted by the renderer during active video.
//   Accumulates player/obstacle and player/wall overlap per frame and evaluates them at each
//   frame boundary.
//   Ignores hits while the game is off and during a post-start grace window.
// PARAMETERS
//   GRACE_FRAMES  30  frame_end pulses ignored after gameon rises (range 0..255)
//   MIN_OVERLAP   4   overlapping pixels in one frame needed to count as a hit (must be >=1)
//   COUNT_W       12  width of the saturating per-frame overlap counters
// PORTS
//   CLOCK_50     in   1        system clock (50 MHz)
//   reset        in   1        synchronous reset, active-low (0 = reset)
//   gameon       in   1        level from game-state controller; 1 = game running
//   pix_valid    in   1        active-video pixel strobe; flags below are valid only when 1
//   frame_end    in   1        one-cycle pulse at the last active pixel / start of vblank
//   player_px    in   1        current pixel belongs to player sprite
//   obstacle_px  in   1        current pixel belongs to an obstacle
//   wall_px      in   1        current pixel belongs to playfield border
//   collision    out  1        one-cycle hit pulse to game-state controller
//   hit_kind     out  2        0 none, 1 obstacle, 2 wall, 3 both; held until next game start
//   hit_count    out  COUNT_W  obstacle-overlap count of the last evaluated frame
// BEHAVIOUR
// - Reset (reset==0 on a clock edge, any state, including mid-frame):
//   - state=IDLE; collision=0, hit_kind=0, hit_count=0; grace counter and both overlap
//     counters cleared.
// - States: IDLE, GRACE, ARMED, FIRED.
//   - IDLE:
//     - gameon==1 -> GRACE; load grace_cnt=GRACE_FRAMES; clear hit_kind, hit_count and
//       overlap counters.
//   - GRACE:
//     - On frame_end: grace_cnt==0 -> ARMED (counters cleared); otherwise grace_cnt-1.
//     - Exits on frame_end number GRACE_FRAMES+1, so accumulation always starts on a
//       frame boundary.
//   - ARMED:
//     - Each cycle with pix_valid&player_px&obstacle_px: obs_cnt+1.
//     - Each cycle with pix_valid&player_px&wall_px: wall_cnt+1.
//     - Both counters saturate at 2^COUNT_W-1; no wrap.
//     - On frame_end: evaluate obs_hit=(obs_cnt'>=MIN_OVERLAP), wall_hit=(wall_cnt'>=MIN_OVERLAP).
//       - cnt' includes a qualifying pixel in the frame_end cycle itself: a coincident pixel
//         belongs to the closing frame.
//       - hit_count<=obs_cnt'. Both counters clear for the next frame.
//       - Any hit -> collision=1 in the following cycle only; hit_kind={wall_hit,obs_hit};
//         state -> FIRED.
//       - No hit -> stay ARMED; hit_kind stays 0.
//   - FIRED:
//     - collision=0; overlaps are ignored; gameon==0 -> IDLE.
//     - A new game re-enters GRACE only via IDLE.
// - gameon==0 in GRACE or ARMED: -> IDLE next cycle; no collision issued.
//   - A frame_end in that same cycle is ignored.
//   - hit_kind/hit_count keep their last values until the next IDLE->GRACE.
// - Latency: collision rises exactly 1 cycle after the evaluating frame_end.
//   - It is a single-cycle pulse, at most one per game.
// - pix_valid==0: overlap counters hold regardless of flag values.
// - Outputs are registered; no combinational path from any input to an output.
// STRUCTURE
//   Shared package/header (game_defs.vh):
//   - State encodings IDLE/GRACE/ARMED/FIRED.
//   - HIT_NONE/HIT_OBST/HIT_WALL/HIT_BOTH codes.
//   - Constants shared with the game-state controller and renderer.
//   One sub-module: overlap_counter.
//   - Parameterised COUNT_W saturating counter with inc, sync clear and active-low reset.
//   - Instantiated twice (obstacle, wall).
//   FSM, grace counter and output registers live in this module.
// TESTING
//   1. Reset mid-ARMED with obs_cnt=7: reset=0 for 3 cycles -> collision=0, hit_kind=0,
//      hit_count=0; no pulse at next frame_end.
//   2. GRACE_FRAMES=2, gameon=1; 10 overlap px in each frame:
//      - No pulse at frame_end #1..#3.
//      - Pulse 1 cycle after frame_end #4; hit_kind=1, hit_count=10.
//   3. MIN_OVERLAP=4, armed:
//      - Frame with 3 obstacle px -> no pulse, hit_count=3.
//      - Next frame with 4 px -> pulse, hit_kind=1, hit_count=4.
//   4. Wall only, 5 px -> hit_kind=2, hit_count=0. New game: 5 wall + 6 obstacle px -> hit_kind=3.
//   5. Threshold pixel coincident with frame_end: 3 earlier px plus 4th px in the frame_end
//      cycle -> pulse, hit_count=4.
//   6. Drop gameon mid-frame in ARMED with 9 px accumulated -> IDLE, no pulse.
//      Separately, COUNT_W=4 with 20 px -> hit_count=15 (saturated).

Source files
------------

// File: rtl/collision_detector_pkg.sv
// rtl/collision_detector_pkg.sv - shared state and hit-kind encodings for the collision detector
package collision_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRACE = 2'd1,
    ST_ARMED = 2'd2,
    ST_FIRED = 2'd3
  } state_t;

  localparam logic [1:0] HIT_NONE = 2'd0;
  localparam logic [1:0] HIT_OBST = 2'd1;
  localparam logic [1:0] HIT_WALL = 2'd2;
  localparam logic [1:0] HIT_BOTH = 2'd3;

  localparam int GRACE_W = 8;

  function automatic logic [1:0] hit_code(input logic wall_hit, input logic obs_hit);
    return {wall_hit, obs_hit};
  endfunction

endpackage

// File: rtl/collision_detector_overlap_counter.sv
// rtl/collision_detector_overlap_counter.sv - saturating overlap counter with sync clear
module collision_detector_overlap_counter #(
  parameter int COUNT_W = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] count_next
);

  // count_next is exposed so the owner can evaluate a pixel landing in the clearing cycle
  always_comb begin
    count_next = count;
    if (inc && (count != {COUNT_W{1'b1}})) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame sprite overlap accumulation and one-shot collision pulse
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int GRACE_FRAMES = 30,
  parameter int MIN_OVERLAP  = 4,
  parameter int COUNT_W      = 12
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               gameon,
  input  logic               pix_valid,
  input  logic               frame_end,
  input  logic               player_px,
  input  logic               obstacle_px,
  input  logic               wall_px,
  output logic               collision,
  output logic [1:0]         hit_kind,
  output logic [COUNT_W-1:0] hit_count
);

  state_t               state, state_next;
  logic [GRACE_W-1:0]   grace_cnt, grace_next;
  logic                 collision_next;
  logic [1:0]           hit_kind_next;
  logic [COUNT_W-1:0]   hit_count_next;

  logic                 armed;
  logic                 obs_inc, wall_inc, cnt_clear;
  logic [COUNT_W-1:0]   obs_cnt, obs_cnt_next, wall_cnt, wall_cnt_next;
  logic                 obs_hit, wall_hit;

  assign armed    = (state == ST_ARMED);
  assign obs_inc  = armed && pix_valid && player_px && obstacle_px;
  assign wall_inc = armed && pix_valid && player_px && wall_px;
  // Counters only run inside an armed frame; everything else leaves them at zero
  assign cnt_clear = !armed || frame_end || !gameon;

  assign obs_hit  = (obs_cnt_next  >= COUNT_W'(MIN_OVERLAP));
  assign wall_hit = (wall_cnt_next >= COUNT_W'(MIN_OVERLAP));

  collision_detector_overlap_counter #(.COUNT_W(COUNT_W)) u_obs_cnt (
    .clk        (CLOCK_50),
    .resetn     (reset),
    .clear      (cnt_clear),
    .inc        (obs_inc),
    .count      (obs_cnt),
    .count_next (obs_cnt_next)
  );

  collision_detector_overlap_counter #(.COUNT_W(COUNT_W)) u_wall_cnt (
    .clk        (CLOCK_50),
    .resetn     (reset),
    .clear      (cnt_clear),
    .inc        (wall_inc),
    .count      (wall_cnt),
    .count_next (wall_cnt_next)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state     <= ST_IDLE;
      grace_cnt <= '0;
      collision <= 1'b0;
      hit_kind  <= HIT_NONE;
      hit_count <= '0;
    end else begin
      state     <= state_next;
      grace_cnt <= grace_next;
      collision <= collision_next;
      hit_kind  <= hit_kind_next;
      hit_count <= hit_count_next;
    end
  end

  always_comb begin
    state_next     = state;
    grace_next     = grace_cnt;
    collision_next = 1'b0;
    hit_kind_next  = hit_kind;
    hit_count_next = hit_count;
    case (state)
      ST_IDLE: begin
        if (gameon) begin
          state_next     = ST_GRACE;
          grace_next     = GRACE_W'(GRACE_FRAMES);
          hit_kind_next  = HIT_NONE;
          hit_count_next = '0;
        end
      end
      ST_GRACE: begin
        if (!gameon) begin
          state_next = ST_IDLE;
        end else if (frame_end) begin
          if (grace_cnt == '0) begin
            state_next = ST_ARMED;
          end else begin
            grace_next = grace_cnt - 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (!gameon) begin
          state_next = ST_IDLE;
        end else if (frame_end) begin
          hit_count_next = obs_cnt_next;
          if (obs_hit || wall_hit) begin
            collision_next = 1'b1;
            hit_kind_next  = hit_code(wall_hit, obs_hit);
            state_next     = ST_FIRED;
          end
        end
      end
      ST_FIRED: begin
        if (!gameon) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
